regfile_wb_arb: RTL and testbench
=================================

Name: regfile_wb_arb

Overview:
- Writeback arbiter that sits directly upstream of the 32x32 register file and is the sole driver of its write port (we3/wa3/wd3).
- Merges two result sources into that single write port:
  - single-cycle ALU results, with no backpressure;
  - multi-cycle mul/div results, via a valid/ready handshake.
- Buffers mul/div results in a small FIFO, filters writes to r0, and reports pending destinations to the hazard unit.

Parameters:
- DEPTH, 2, mul/div FIFO entries (power of 2, ≥2).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  rising-edge clock, shared with regfile.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle; always highest priority, never stalled.
- alu_wa  in  ADDR_W  ALU destination register.
- alu_wd  in  DATA_W  ALU result data.
- md_valid  in  1  mul/div result offered.
- md_ready  out  1  FIFO can accept; transfer when md_valid && md_ready.
- md_wa  in  ADDR_W  mul/div destination register.
- md_wd  in  DATA_W  mul/div result data.
- we3  out  1  regfile write enable (registered).
- wa3  out  ADDR_W  regfile write address (registered).
- wd3  out  DATA_W  regfile write data (registered).
- chk_a1, chk_a2  in  ADDR_W  hazard-query addresses (decode-stage ra1/ra2).
- pend_hit1, pend_hit2  out  1  combinational; chk_aN ≠ 0 and matches a valid FIFO entry or the current wa3 with we3=1.
- fifo_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy.
- err_waw  out  1  sticky; alu_valid with alu_wa ≠ 0 matching a valid FIFO entry. Cleared only by reset.

Behaviour:
- Reset (synchronous, sampled on clk rising edge):
  - we3=0, wa3=0, wd3=0, fifo_cnt=0, err_waw=0; FIFO flushed.
  - md_ready=0 while reset=1; md_ready=1 in the first cycle after reset deasserts.
  - Reset mid-operation discards all buffered results; no write is issued for them.
- Latency: a result selected in cycle N appears on we3/wa3/wd3 in cycle N+1. The regfile commits it at the edge ending cycle N+1.
- Per-cycle selection, in priority order:
  - ALU: if alu_valid && alu_wa ≠ 0, select the ALU result; the FIFO does not pop.
  - FIFO: else, if FIFO non-empty, pop the head and select it.
  - Idle: else, we3=0 next cycle; wa3/wd3 hold their previous values.
- ALU write to r0 (alu_valid && alu_wa=0): treated as no ALU request, so the FIFO may pop that cycle.
- md_ready = (fifo_cnt < DEPTH), derived from registered state only. No same-cycle push-on-pop when full: when full, md_ready=0 even if a pop occurs.
- Accepted md result with md_wa=0: consumed (handshake completes) but not pushed; fifo_cnt unchanged.
- Simultaneous push and pop when non-full: fifo_cnt unchanged; order preserved.
- FIFO pointers wrap modulo DEPTH.
- fifo_cnt never exceeds DEPTH or underflows.
- FIFO drain order is strict FIFO.
- The ALU may overtake buffered mul/div results.
- WAW ordering is the hazard unit's responsibility, via pend_hitN. If it is violated, err_waw is set and writes still proceed in arbitration order.
- pend_hitN compares ignore address 0.

Decomposition:
- Package regfile_pkg:
  - ADDR_W, DATA_W constants;
  - typedef wb_req_t struct {logic [ADDR_W-1:0] wa; logic [DATA_W-1:0] wd;}.
- Sub-module wb_fifo: a synchronous FIFO of wb_req_t with push, pop, full, empty, count, and per-entry valid/address visibility for the hazard compares.
- Top level holds arbitration, the output register, the r0 filter, and err_waw.

Test Plan:
- Reset then idle: we3=0, wa3=0, wd3=0, md_ready=1, fifo_cnt=0.
- ALU only: alu_valid=1, alu_wa=3, alu_wd=0x3 in cycle N -> cycle N+1 we3=1, wa3=3, wd3=0x3; regfile rd of r3 returns 0x3 the following cycle.
- Contention:
  - Stimulus: md write (wa=5, wd=0x55) accepted in cycle N, with alu_valid (wa=7, wd=0x77) asserted in cycles N+1..N+3.
  - Response: ALU writes of r7 appear in cycles N+2..N+4; fifo_cnt=1 throughout those ALU cycles; r5/0x55 appears in cycle N+5.
  - pend_hit1=1 for chk_a1=5 until the r5 write has been issued.
- Full FIFO: with DEPTH=2, push md results wa=1,2 while alu_valid is held with wa=9 -> fifo_cnt=2, md_ready=0; a third md_valid stalls; releasing the ALU drains r1 then r2, and md_ready returns to 1 the cycle after the first pop.
- r0 filtering:
  - alu_valid with wa=0 -> we3 stays 0, and a pending FIFO entry pops in that same cycle.
  - md write with wa=0 -> handshake completes, fifo_cnt unchanged, no write issued.
- Reset mid-drain and WAW:
  - Stimulus: FIFO holds 2 entries; assert reset for 1 cycle.
  - Response: fifo_cnt=0, we3=0, no writes issued for the flushed entries.
  - Then alu_wa=4 while FIFO holds wa=4 -> err_waw=1 and stays 1 until the next reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and the writeback request type used by the arbiter and its FIFO.
package regfile_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arb_if.sv
// Result sources in, regfile write port out. The master drives results; the arbiter is the slave.
interface regfile_wb_arb_if
    import regfile_pkg::*;
();

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_wa;
    logic [DATA_W-1:0] alu_wd;
    logic              md_valid;
    logic              md_ready;
    logic [ADDR_W-1:0] md_wa;
    logic [DATA_W-1:0] md_wd;
    logic              we3;
    logic [ADDR_W-1:0] wa3;
    logic [DATA_W-1:0] wd3;

    modport master (
        output alu_valid, alu_wa, alu_wd, md_valid, md_wa, md_wd,
        input  md_ready, we3, wa3, wd3
    );

    modport slave (
        input  alu_valid, alu_wa, alu_wd, md_valid, md_wa, md_wd,
        output md_ready, we3, wa3, wd3
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; exposes per-entry valid/address for hazard compares.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          push_i,
    input  wb_req_t                       push_data_i,
    input  logic                          pop_i,
    output wb_req_t                       head_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(DEPTH):0]        cnt_o,
    output logic [DEPTH-1:0]              entry_valid_o,
    output logic [DEPTH-1:0][ADDR_W-1:0]  entry_wa_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    wb_req_t         mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            push_ok, pop_ok;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        cnt_d = cnt_q + CntW'(push_ok) - CntW'(pop_ok);
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [PtrW-1:0] off;
            off              = PtrW'(i) - rd_ptr_q;
            entry_valid_o[i] = ({1'b0, off} < cnt_q);
            entry_wa_o[i]    = mem_q[i].wa;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/regfile_wb_arb.sv
// Writeback arbiter: ALU results take priority, buffered mul/div results fill idle slots.
module regfile_wb_arb
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_wb_arb_if.slave        wb,
    input  logic [ADDR_W-1:0]      chk_a1,
    input  logic [ADDR_W-1:0]      chk_a2,
    output logic                   pend_hit1,
    output logic                   pend_hit2,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic                   err_waw
);

    wb_req_t                     head;
    logic                        full, empty, alu_sel, pop, push, waw_hit;
    logic [DEPTH-1:0]            entry_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_wa;

    logic              we3_q, we3_d;
    logic [ADDR_W-1:0] wa3_q, wa3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;
    logic              err_waw_q, err_waw_d;

    // Writes to r0 are dropped: an ALU r0 write frees the slot, an md r0 result is consumed.
    assign alu_sel     = wb.alu_valid && (wb.alu_wa != '0);
    assign pop         = !alu_sel && !empty;
    assign wb.md_ready = !reset && !full;
    assign push        = wb.md_valid && wb.md_ready && (wb.md_wa != '0);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i         (clk),
        .reset_i       (reset),
        .push_i        (push),
        .push_data_i   ('{wa: wb.md_wa, wd: wb.md_wd}),
        .pop_i         (pop),
        .head_o        (head),
        .full_o        (full),
        .empty_o       (empty),
        .cnt_o         (fifo_cnt),
        .entry_valid_o (entry_valid),
        .entry_wa_o    (entry_wa)
    );

    always_comb begin
        pend_hit1 = 1'b0;
        pend_hit2 = 1'b0;
        waw_hit   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && entry_wa[i] == chk_a1)    pend_hit1 = 1'b1;
            if (entry_valid[i] && entry_wa[i] == chk_a2)    pend_hit2 = 1'b1;
            if (entry_valid[i] && entry_wa[i] == wb.alu_wa) waw_hit   = 1'b1;
        end
        if (we3_q && wa3_q == chk_a1) pend_hit1 = 1'b1;
        if (we3_q && wa3_q == chk_a2) pend_hit2 = 1'b1;
        if (chk_a1 == '0) pend_hit1 = 1'b0;
        if (chk_a2 == '0) pend_hit2 = 1'b0;
    end

    always_comb begin
        we3_d     = alu_sel || pop;
        wa3_d     = wa3_q;
        wd3_d     = wd3_q;
        err_waw_d = err_waw_q || (alu_sel && waw_hit);
        if (alu_sel) begin
            wa3_d = wb.alu_wa;
            wd3_d = wb.alu_wd;
        end else if (pop) begin
            wa3_d = head.wa;
            wd3_d = head.wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we3_q     <= 1'b0;
            wa3_q     <= '0;
            wd3_q     <= '0;
            err_waw_q <= 1'b0;
        end else begin
            we3_q     <= we3_d;
            wa3_q     <= wa3_d;
            wd3_q     <= wd3_d;
            err_waw_q <= err_waw_d;
        end
    end

    assign wb.we3  = we3_q;
    assign wb.wa3  = wa3_q;
    assign wb.wd3  = wd3_q;
    assign err_waw = err_waw_q;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb with a small regfile model on the write port.
module tb_regfile_wb_arb;
    import regfile_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic                   clk;
    logic                   reset;
    logic [ADDR_W-1:0]      chk_a1, chk_a2;
    logic                   pend_hit1, pend_hit2;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic                   err_waw;
    logic [DATA_W-1:0]      rf [32];
    int                     n_cmp = 0;
    int                     n_err = 0;

    regfile_wb_arb_if bus ();

    regfile_wb_arb #(
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wb        (bus),
        .chk_a1    (chk_a1),
        .chk_a2    (chk_a2),
        .pend_hit1 (pend_hit1),
        .pend_hit2 (pend_hit2),
        .fifo_cnt  (fifo_cnt),
        .err_waw   (err_waw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.we3) rf[bus.wa3] <= bus.wd3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd);
        chk({tag, ".we3"}, 32'(bus.we3), 32'(we));
        chk({tag, ".wa3"}, 32'(bus.wa3), 32'(wa));
        chk({tag, ".wd3"}, bus.wd3, wd);
    endtask

    task automatic alu(input logic v, input logic [4:0] wa, input logic [31:0] wd);
        bus.alu_valid = v;
        bus.alu_wa    = wa;
        bus.alu_wd    = wd;
    endtask

    task automatic md(input logic v, input logic [4:0] wa, input logic [31:0] wd);
        bus.md_valid = v;
        bus.md_wa    = wa;
        bus.md_wd    = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b1;
        chk_a1 = '0;
        chk_a2 = '0;
        alu(1'b0, 5'd0, 32'h0);
        md(1'b0, 5'd0, 32'h0);
        tick();
        tick();
        chk("rst.md_ready_low", 32'(bus.md_ready), 32'd0);

        // Reset then idle
        reset = 1'b0;
        tick();
        chk_wr("idle", 1'b0, 5'd0, 32'h0);
        chk("idle.md_ready", 32'(bus.md_ready), 32'd1);
        chk("idle.cnt", 32'(fifo_cnt), 32'd0);
        chk("idle.err", 32'(err_waw), 32'd0);

        // ALU only, one cycle latency, hold on idle
        alu(1'b1, 5'd3, 32'h3);
        tick();
        chk_wr("alu", 1'b1, 5'd3, 32'h3);
        alu(1'b0, 5'd0, 32'h0);
        tick();
        chk_wr("alu.hold", 1'b0, 5'd3, 32'h3);
        chk("alu.rf3", rf[3], 32'h3);

        // Contention: md r5 buffered behind three ALU r7 writes
        chk_a1 = 5'd5;
        md(1'b1, 5'd5, 32'h55);
        tick();
        chk("cont.cnt_push", 32'(fifo_cnt), 32'd1);
        chk("cont.we3_idle", 32'(bus.we3), 32'd0);
        md(1'b0, 5'd0, 32'h0);
        alu(1'b1, 5'd7, 32'h77);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_wr("cont.alu7", 1'b1, 5'd7, 32'h77);
            chk("cont.cnt", 32'(fifo_cnt), 32'd1);
            chk("cont.pend1", 32'(pend_hit1), 32'd1);
        end
        alu(1'b0, 5'd0, 32'h0);
        tick();
        chk_wr("cont.md5", 1'b1, 5'd5, 32'h55);
        chk("cont.cnt0", 32'(fifo_cnt), 32'd0);
        chk("cont.pend1_wa3", 32'(pend_hit1), 32'd1);
        tick();
        chk("cont.pend1_clr", 32'(pend_hit1), 32'd0);
        chk("cont.err", 32'(err_waw), 32'd0);
        chk_a1 = '0;

        // Full FIFO with ALU holding the port
        alu(1'b1, 5'd9, 32'h99);
        md(1'b1, 5'd1, 32'h11);
        tick();
        chk("full.cnt1", 32'(fifo_cnt), 32'd1);
        md(1'b1, 5'd2, 32'h22);
        tick();
        chk("full.cnt2", 32'(fifo_cnt), 32'd2);
        chk("full.ready0", 32'(bus.md_ready), 32'd0);
        md(1'b1, 5'd3, 32'h33);
        tick();
        chk("full.stall_cnt", 32'(fifo_cnt), 32'd2);
        chk("full.stall_ready", 32'(bus.md_ready), 32'd0);
        chk_wr("full.alu9", 1'b1, 5'd9, 32'h99);
        alu(1'b0, 5'd0, 32'h0);
        tick();
        chk_wr("full.pop1", 1'b1, 5'd1, 32'h11);
        chk("full.cnt_pop", 32'(fifo_cnt), 32'd1);
        chk("full.ready1", 32'(bus.md_ready), 32'd1);
        tick();
        chk_wr("full.pop2", 1'b1, 5'd2, 32'h22);
        chk("full.cnt_pushpop", 32'(fifo_cnt), 32'd1);
        md(1'b0, 5'd0, 32'h0);
        tick();
        chk_wr("full.pop3", 1'b1, 5'd3, 32'h33);
        chk("full.cnt_empty", 32'(fifo_cnt), 32'd0);
        tick();
        chk("full.we3_idle", 32'(bus.we3), 32'd0);

        // r0 filtering
        md(1'b1, 5'd6, 32'h66);
        tick();
        md(1'b0, 5'd0, 32'h0);
        chk("r0.cnt1", 32'(fifo_cnt), 32'd1);
        alu(1'b1, 5'd0, 32'hdead);
        tick();
        chk_wr("r0.pop6", 1'b1, 5'd6, 32'h66);
        chk("r0.cnt0", 32'(fifo_cnt), 32'd0);
        tick();
        chk("r0.alu_nowrite", 32'(bus.we3), 32'd0);
        alu(1'b0, 5'd0, 32'h0);
        md(1'b1, 5'd0, 32'h12);
        #1;
        chk("r0.md_ready", 32'(bus.md_ready), 32'd1);
        tick();
        md(1'b0, 5'd0, 32'h0);
        chk("r0.md_cnt", 32'(fifo_cnt), 32'd0);
        tick();
        chk_wr("r0.md_nowrite", 1'b0, 5'd6, 32'h66);

        // Reset mid-drain flushes buffered results
        alu(1'b1, 5'd9, 32'h99);
        md(1'b1, 5'd4, 32'h44);
        tick();
        md(1'b1, 5'd8, 32'h88);
        tick();
        chk("rst.cnt2", 32'(fifo_cnt), 32'd2);
        alu(1'b0, 5'd0, 32'h0);
        md(1'b0, 5'd0, 32'h0);
        reset = 1'b1;
        tick();
        chk_wr("rst.regs", 1'b0, 5'd0, 32'h0);
        chk("rst.cnt0", 32'(fifo_cnt), 32'd0);
        reset = 1'b0;
        tick();
        chk("rst.nowrite1", 32'(bus.we3), 32'd0);
        tick();
        chk("rst.nowrite2", 32'(bus.we3), 32'd0);
        chk("rst.cnt_after", 32'(fifo_cnt), 32'd0);

        // WAW: ALU overtakes a buffered result to the same register
        chk_a2 = 5'd4;
        md(1'b1, 5'd4, 32'h44);
        tick();
        md(1'b0, 5'd0, 32'h0);
        chk("waw.pend2", 32'(pend_hit2), 32'd1);
        chk("waw.err0", 32'(err_waw), 32'd0);
        alu(1'b1, 5'd4, 32'h40);
        tick();
        chk("waw.err1", 32'(err_waw), 32'd1);
        chk_wr("waw.alu4", 1'b1, 5'd4, 32'h40);
        alu(1'b0, 5'd0, 32'h0);
        tick();
        chk_wr("waw.md4", 1'b1, 5'd4, 32'h44);
        chk("waw.err_sticky", 32'(err_waw), 32'd1);
        tick();
        chk("waw.err_sticky2", 32'(err_waw), 32'd1);
        chk("waw.pend2_clr", 32'(pend_hit2), 32'd0);
        chk_a2 = '0;
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("waw.err_reset", 32'(err_waw), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
